spc2_cfg_tx: RTL and testbench

Serial configuration transmitter: the controller end of the SPC2 configuration shift chain.
- Accepts a parallel 16-bit config word (F[3:0], IQ, GS[3:0], CE, NS, GD[2:0], FS, RE, packed MSB to LSB) and drives the chip's serial interface: chain reset (active-low), divided shift clock and data, LSB first.
- Sits in the FPGA control path, between the host/UART register file and the SPC2 config pins.

---
 rtl/spc2_cfg_tx.sv | 176 +++++++++++++++++
 tb/tb_spc2_cfg_tx.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/spc2_cfg_tx.sv
// spc2_cfg_tx: controller end of the SPC2 serial configuration chain.
// Takes a parallel config word, pulses the chain reset low, then shifts the
// word out LSB first on a divided shift clock. Data changes on falling edges
// so the chip gets a full half period of setup and hold around each rising edge.
// Optional feature macro: SPC_TX_STROBE_EN adds a latch strobe after the last bit.
module spc2_cfg_tx #(
  parameter int WIDTH     = 16,  // config word length (>=2)
  parameter int DIV_HALF  = 5,   // Clk cycles per Spc_clk half period (>=1)
  parameter int RST_TICKS = 2    // half periods of chain reset before shifting (>=1)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             start,
  input  logic [WIDTH-1:0] cfg_word,
  output logic             busy,
  output logic             done,
  output logic             Spc_clk,
  output logic             Spc_resetn,
  output logic             Spc_data,
  output logic             Spc_strobe
);

  localparam int DW = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;
  localparam int BW = $clog2(WIDTH + 1);
  localparam int TW = $clog2(RST_TICKS + 2);

  typedef enum logic [2:0] {
    IDLE,
    RST,
    SHIFT,
    DONE
`ifdef SPC_TX_STROBE_EN
    , STROBE
`endif
  } state_t;

  // Where SHIFT goes after the last falling edge.
`ifdef SPC_TX_STROBE_EN
  localparam state_t AFTER_SHIFT = STROBE;
`else
  localparam state_t AFTER_SHIFT = DONE;
`endif

  state_t           state, state_nx;
  logic [DW-1:0]    div, div_nx;      // Clk cycles within the current half period
  logic [BW-1:0]    bcnt, bcnt_nx;    // bits completed (falling edges seen)
  logic [TW-1:0]    tcnt, tcnt_nx;    // ticks spent in RST / STROBE
  logic [WIDTH-1:0] sreg, sreg_nx;    // captured word, shifted right per bit
  logic             sclk, sclk_nx;
  logic             sdata, sdata_nx;
  logic             tick;

  // A tick ends every half period; the divider only runs outside IDLE.
  assign tick = (state != IDLE) && (div == DW'(DIV_HALF - 1));

  // State and datapath registers; reset abandons any transfer in flight.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      div   <= '0;
      bcnt  <= '0;
      tcnt  <= '0;
      sreg  <= '0;
      sclk  <= 1'b0;
      sdata <= 1'b0;
    end else begin
      state <= state_nx;
      div   <= div_nx;
      bcnt  <= bcnt_nx;
      tcnt  <= tcnt_nx;
      sreg  <= sreg_nx;
      sclk  <= sclk_nx;
      sdata <= sdata_nx;
    end
  end

  // Next-state and next-datapath logic; every phase is measured in ticks.
  always_comb begin
    state_nx = state;
    bcnt_nx  = bcnt;
    tcnt_nx  = tcnt;
    sreg_nx  = sreg;
    sclk_nx  = sclk;
    sdata_nx = sdata;
    if (state == IDLE || tick) div_nx = '0;
    else                       div_nx = div + DW'(1);

    case (state)
      IDLE: begin
        sclk_nx  = 1'b0;
        sdata_nx = 1'b0;
        if (start) begin
          sreg_nx  = cfg_word;
          bcnt_nx  = '0;
          tcnt_nx  = '0;
          state_nx = RST;
        end
      end

      RST: begin
        sclk_nx = 1'b0;
        if (tick) begin
          if (tcnt == TW'(RST_TICKS - 1)) begin
            // Present bit 0 for a full half period before the first rise.
            tcnt_nx  = '0;
            sdata_nx = sreg[0];
            state_nx = SHIFT;
          end else begin
            tcnt_nx = tcnt + TW'(1);
          end
        end
      end

      SHIFT: begin
        if (tick) begin
          sclk_nx = ~sclk;
          if (sclk) begin
            // Falling edge: the chip has sampled the current bit.
            bcnt_nx = bcnt + BW'(1);
            if (bcnt == BW'(WIDTH - 1)) begin
              tcnt_nx  = '0;
              state_nx = AFTER_SHIFT;
`ifndef SPC_TX_STROBE_EN
              sdata_nx = 1'b0;
`endif
            end else begin
              sreg_nx  = {1'b0, sreg[WIDTH-1:1]};
              sdata_nx = sreg[1];
            end
          end
        end
      end

`ifdef SPC_TX_STROBE_EN
      STROBE: begin
        // Strobe lasts one full Spc_clk period with the shift clock parked low.
        sclk_nx = 1'b0;
        if (tick) begin
          if (tcnt == TW'(1)) begin
            tcnt_nx  = '0;
            sdata_nx = 1'b0;
            state_nx = DONE;
          end else begin
            tcnt_nx = tcnt + TW'(1);
          end
        end
      end
`endif

      DONE: begin
        sclk_nx  = 1'b0;
        sdata_nx = 1'b0;
        state_nx = IDLE;
      end

      default: begin
        state_nx = IDLE;
      end
    endcase

    // Every phase starts with a fresh half period.
    if (state_nx != state) div_nx = '0;
  end

  assign busy       = (state != IDLE) && (state != DONE);
  assign done       = (state == DONE);
  assign Spc_clk    = sclk;
  assign Spc_resetn = (state != RST);
  assign Spc_data   = sdata;
`ifdef SPC_TX_STROBE_EN
  assign Spc_strobe = (state == STROBE);
`else
  assign Spc_strobe = 1'b0;
`endif

endmodule

// File: tb/tb_spc2_cfg_tx.sv
// Bench for spc2_cfg_tx: a default-parameter instance and a small
// (WIDTH=4, DIV_HALF=1, RST_TICKS=1) instance. Stimulus pushes expected
// transfers into per-instance queues; a monitor deserialises the chip side
// and checks each transfer when done pulses.
module tb_spc2_cfg_tx;

`ifdef SPC_TX_STROBE_EN
  localparam int STRB = 1;
`else
  localparam int STRB = 0;
`endif

  typedef struct {
    logic [15:0] word;
    int          nbits;
    int          busy;
    int          rlen;
    int          slen;
    int          edges;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0, rst1, start0, start1;
  logic [15:0] cfg0;
  logic [3:0]  cfg1;
  logic d0_busy, d0_done, d0_sclk, d0_rstn, d0_data, d0_strb;
  logic d1_busy, d1_done, d1_sclk, d1_rstn, d1_data, d1_strb;

  spc2_cfg_tx dut0 (
    .Clk(clk), .Reset(rst0), .start(start0), .cfg_word(cfg0),
    .busy(d0_busy), .done(d0_done), .Spc_clk(d0_sclk),
    .Spc_resetn(d0_rstn), .Spc_data(d0_data), .Spc_strobe(d0_strb));

  spc2_cfg_tx #(.WIDTH(4), .DIV_HALF(1), .RST_TICKS(1)) dut1 (
    .Clk(clk), .Reset(rst1), .start(start1), .cfg_word(cfg1),
    .busy(d1_busy), .done(d1_done), .Spc_clk(d1_sclk),
    .Spc_resetn(d1_rstn), .Spc_data(d1_data), .Spc_strobe(d1_strb));

  int checks = 0;
  int errors = 0;
  exp_t q0[$];
  exp_t q1[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic exp_t mk0(input logic [15:0] w);
    exp_t e;
    e.word = w; e.nbits = 16; e.busy = 170 + 10*STRB; e.rlen = 10;
    e.slen = 10*STRB; e.edges = 31 + STRB;
    return e;
  endfunction

  function automatic exp_t mk1(input logic [3:0] w);
    exp_t e;
    e.word = {12'h0, w}; e.nbits = 4; e.busy = 9 + 2*STRB; e.rlen = 1;
    e.slen = 2*STRB; e.edges = 7 + STRB;
    return e;
  endfunction

  // ---------------- monitor ----------------
  logic [1:0] m_rst, m_busy, m_done, m_sclk, m_rstn, m_data, m_strb;
  assign m_rst  = {rst1, rst0};
  assign m_busy = {d1_busy, d0_busy};
  assign m_done = {d1_done, d0_done};
  assign m_sclk = {d1_sclk, d0_sclk};
  assign m_rstn = {d1_rstn, d0_rstn};
  assign m_data = {d1_data, d0_data};
  assign m_strb = {d1_strb, d0_strb};

  logic [15:0] rx[2];
  int nb[2], bcnt[2], rcnt[2], scnt[2], edg[2], dviol[2], sviol[2], oviol[2];
  logic [1:0] p_busy, p_done, p_sclk, p_rstn, p_data;

  task automatic clr(input int i);
    rx[i] = '0; nb[i] = 0; bcnt[i] = 0; rcnt[i] = 0; scnt[i] = 0;
    edg[i] = 0; dviol[i] = 0; sviol[i] = 0; oviol[i] = 0;
  endtask

  initial begin
    exp_t e;
    string n;
    clr(0); clr(1);
    p_busy = '0; p_done = '0; p_sclk = '0; p_rstn = '1; p_data = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (m_rst[i]) begin
          clr(i);
        end else begin
          if (m_busy[i] && m_done[i]) oviol[i]++;
          if (m_done[i] && p_done[i]) oviol[i]++;
          if (m_busy[i]) bcnt[i]++;
          if (m_busy[i] && !m_rstn[i] && nb[i] == 0) rcnt[i]++;
          if (m_busy[i] && p_busy[i] && m_sclk[i] != p_sclk[i]) edg[i]++;
          if (m_sclk[i] && !p_sclk[i]) begin
            rx[i] = rx[i] | (16'(m_data[i]) << nb[i]);
            nb[i]++;
          end
          if (p_busy[i] && m_busy[i] && p_rstn[i] && m_data[i] != p_data[i] &&
              !(p_sclk[i] && !m_sclk[i])) dviol[i]++;
          if (m_strb[i]) begin
            scnt[i]++;
            if (m_sclk[i]) sviol[i]++;
          end
          if (m_done[i]) begin
            n = $sformatf("dut%0d", i);
            if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
              checks++; errors++;
              $display("FAIL %s unexpected_done: got done with no transfer outstanding", n);
            end else begin
              e = (i == 0) ? q0.pop_front() : q1.pop_front();
              chk({n, " word"},       int'(rx[i]), int'(e.word));
              chk({n, " rise_count"}, nb[i],   e.nbits);
              chk({n, " busy_len"},   bcnt[i], e.busy);
              chk({n, " resetn_len"}, rcnt[i], e.rlen);
              chk({n, " strobe_len"}, scnt[i], e.slen);
              chk({n, " sclk_edges"}, edg[i],  e.edges);
              chk({n, " data_off_fall"}, dviol[i], 0);
              chk({n, " strobe_sclk"},   sviol[i], 0);
              chk({n, " busy_done_ovl"}, oviol[i], 0);
            end
            clr(i);
          end
        end
      end
      p_busy = m_busy; p_done = m_done; p_sclk = m_sclk; p_rstn = m_rstn; p_data = m_data;
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_done(input int inst, input int bound, input string name);
    int k;
    for (k = 0; k < bound; k++) begin
      @(negedge clk);
      if ((inst == 0) ? d0_done : d1_done) break;
    end
    chk({name, " done_seen"}, int'(k < bound), 1);
  endtask

  task automatic send0(input logic [15:0] w);
    @(negedge clk);
    cfg0 = w; start0 = 1'b1;
    q0.push_back(mk0(w));
    @(negedge clk);
    start0 = 1'b0;
    cfg0 = ~w;
    wait_done(0, 400, $sformatf("send0_%h", w));
  endtask

  initial begin
    int cnt;
    rst0 = 1'b1; rst1 = 1'b1; start0 = 1'b0; start1 = 1'b0;
    cfg0 = '0; cfg1 = '0;
    #2;
    chk("reset_outs0", int'({d0_busy, d0_done, d0_sclk, d0_rstn, d0_data, d0_strb}), 6'b000100);
    chk("reset_outs1", int'({d1_busy, d1_done, d1_sclk, d1_rstn, d1_data, d1_strb}), 6'b000100);
    repeat (3) @(negedge clk);
    rst0 = 1'b0; rst1 = 1'b0;
    repeat (2) @(negedge clk);

    // Plain transfers, including edge bit patterns.
    send0(16'h0561);
    send0(16'h0657);
    send0(16'h8001);

    // Start held high, cfg_word changed mid-transfer, back-to-back restart.
    @(negedge clk);
    cfg0 = 16'h0561; start0 = 1'b1;
    q0.push_back(mk0(16'h0561));
    q0.push_back(mk0(16'hA5A5));
    repeat (60) @(negedge clk);
    cfg0 = 16'hA5A5;
    wait_done(0, 400, "held_first");
    @(negedge clk);
    chk("b2b_idle_busy", int'(d0_busy), 0);
    @(negedge clk);
    chk("b2b_rst_phase", int'({d0_busy, d0_rstn}), 2'b10);
    start0 = 1'b0;
    wait_done(0, 400, "held_second");

    // Small instance: every-cycle shift clock.
    @(negedge clk);
    cfg1 = 4'b1010; start1 = 1'b1;
    q1.push_back(mk1(4'b1010));
    @(negedge clk);
    start1 = 1'b0; cfg1 = 4'b0101;
    wait_done(1, 40, "small");

    // Asynchronous reset around bit 7; transfer must be abandoned.
    @(negedge clk);
    cfg0 = 16'hFFFF; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (84) @(negedge clk);
    chk("pre_rst_busy", int'(d0_busy), 1);
    #2 rst0 = 1'b1;
    #1;
    chk("async_rst_outs", int'({d0_busy, d0_done, d0_sclk, d0_rstn, d0_data, d0_strb}), 6'b000100);
    repeat (2) @(negedge clk);
    rst0 = 1'b0;
    cnt = 0;
    repeat (200) begin
      @(negedge clk);
      if (d0_sclk || d0_busy || d0_done || !d0_rstn) cnt++;
    end
    chk("idle_after_rst", cnt, 0);

    repeat (3) @(negedge clk);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
